// File: rtl/sprite_compositor.sv
// N-sprite compositor: double-buffered positions/enables committed at frame start, priority pixel select, per-frame collisions.
// 1-clock latency on pixel outputs; no backpressure, one pixel per clock with inputs always accepted.
module sprite_compositor #(
    parameter int                NSPR       = 4,
    parameter int                CORDW      = 16,
    parameter int                CIDXW      = 4,
    parameter logic [CIDXW-1:0]  TRANS_INDX = CIDXW'(4'hF),
    parameter int                ADDRW      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame,
    input  logic                    bright,
    input  logic                    wr_en,
    input  logic [ADDRW-1:0]        wr_addr,
    input  logic [CORDW-1:0]        wr_data,
    input  logic [NSPR-1:0]         spr_draw,
    input  logic [NSPR*CIDXW-1:0]   spr_pix,
    output logic [NSPR*CORDW-1:0]   sprx_out,
    output logic [NSPR*CORDW-1:0]   spry_out,
    output logic [CIDXW-1:0]        pix_idx,
    output logic                    pix_valid,
    output logic                    bright_d,
    output logic [NSPR-1:0]         collision,
    output logic                    coll_any,
    output logic                    commit
);

    localparam logic [ADDRW-1:0] EN_ADDR = ADDRW'(2 * NSPR);

    logic [NSPR-1:0][CORDW-1:0] sx_sh;
    logic [NSPR-1:0][CORDW-1:0] sy_sh;
    logic [NSPR-1:0][CORDW-1:0] sx_act;
    logic [NSPR-1:0][CORDW-1:0] sy_act;
    logic [NSPR-1:0]            en_sh;
    logic [NSPR-1:0]            en_act;
    logic                       dirty;
    logic                       addr_ok;
    logic                       do_commit;

    logic [NSPR-1:0]            opq;
    logic                       multi_opq;
    logic [CIDXW-1:0]           win_idx;
    logic [NSPR-1:0]            coll_acc;

    assign addr_ok   = wr_en && (wr_addr <= EN_ADDR);
    assign do_commit = frame && dirty;

    // Shadow registers: written any time, only visible after a frame commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sx_sh <= '0;
            sy_sh <= '0;
            en_sh <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NSPR; i++) begin
                if (wr_addr == ADDRW'(2 * i))
                    sx_sh[i] <= wr_data;
                if (wr_addr == ADDRW'(2 * i + 1))
                    sy_sh[i] <= wr_data;
            end
            if (wr_addr == EN_ADDR)
                en_sh <= wr_data[NSPR-1:0];
        end
    end

    // A write in the frame cycle re-arms dirty so it lands on the following frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sx_act <= '0;
            sy_act <= '0;
            en_act <= '0;
            dirty  <= 1'b0;
            commit <= 1'b0;
        end else begin
            commit <= do_commit;
            if (do_commit) begin
                sx_act <= sx_sh;
                sy_act <= sy_sh;
                en_act <= en_sh;
            end
            if (addr_ok)
                dirty <= 1'b1;
            else if (frame)
                dirty <= 1'b0;
        end
    end

    assign sprx_out = sx_act;
    assign spry_out = sy_act;

    always_comb begin
        for (int i = 0; i < NSPR; i++)
            opq[i] = en_act[i] & spr_draw[i] & (spr_pix[i*CIDXW +: CIDXW] != TRANS_INDX);
    end

    // Scan high to low so the lowest opaque index is the last one assigned.
    always_comb begin
        win_idx = '0;
        for (int i = NSPR - 1; i >= 0; i--) begin
            if (opq[i])
                win_idx = spr_pix[i*CIDXW +: CIDXW];
        end
    end

    assign multi_opq = |(opq & (opq - NSPR'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_idx   <= '0;
            pix_valid <= 1'b0;
            bright_d  <= 1'b0;
        end else begin
            pix_idx   <= win_idx;
            pix_valid <= |opq;
            bright_d  <= bright;
        end
    end

    // Frame cycle publishes the finished frame and drops its own overlaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            coll_acc  <= '0;
            collision <= '0;
        end else if (frame) begin
            collision <= coll_acc;
            coll_acc  <= '0;
        end else if (bright && multi_opq) begin
            coll_acc  <= coll_acc | opq;
        end
    end

    assign coll_any = |collision;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor; expectations queued by the driver, checked by an independent monitor.
module tb_sprite_compositor;

    logic        clk;
    logic        rst;
    logic        frame;
    logic        bright;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  spr_draw;
    logic [15:0] spr_pix;
    logic [63:0] sprx_out;
    logic [63:0] spry_out;
    logic [3:0]  pix_idx;
    logic        pix_valid;
    logic        bright_d;
    logic [3:0]  collision;
    logic        coll_any;
    logic        commit;

    sprite_compositor dut (
        .clk       (clk),
        .rst       (rst),
        .frame     (frame),
        .bright    (bright),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .spr_draw  (spr_draw),
        .spr_pix   (spr_pix),
        .sprx_out  (sprx_out),
        .spry_out  (spry_out),
        .pix_idx   (pix_idx),
        .pix_valid (pix_valid),
        .bright_d  (bright_d),
        .collision (collision),
        .coll_any  (coll_any),
        .commit    (commit)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    typedef struct {
        int          tag;
        bit          c_pix;
        logic [3:0]  idx;
        logic        vld;
        logic        bd;
        bit          c_cm;
        logic        cm;
        bit          c_col;
        logic [3:0]  col;
        bit          c_pos;
        int          spr;
        logic [15:0] x;
        logic [15:0] y;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   tag_n  = 0;

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", nm, tag, act, expv);
        end
    endtask

    task automatic clr_exp();
        e.c_pix = 0; e.idx = '0; e.vld = 0; e.bd = 0;
        e.c_cm  = 0; e.cm = 0;
        e.c_col = 0; e.col = '0;
        e.c_pos = 0; e.spr = 0; e.x = '0; e.y = '0;
    endtask

    task automatic expix(input logic [3:0] idx, input logic vld, input logic bd);
        e.c_pix = 1; e.idx = idx; e.vld = vld; e.bd = bd;
    endtask

    task automatic excm(input logic cm);
        e.c_cm = 1; e.cm = cm;
    endtask

    task automatic excol(input logic [3:0] col);
        e.c_col = 1; e.col = col;
    endtask

    task automatic expos(input int spr, input logic [15:0] x, input logic [15:0] y);
        e.c_pos = 1; e.spr = spr; e.x = x; e.y = y;
    endtask

    // One entry per clock keeps the queue aligned with the monitor's pops.
    task automatic tick();
        tag_n++;
        e.tag = tag_n;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        clr_exp();
    endtask

    task automatic wr(input logic [3:0] addr, input logic [15:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic drive(input logic [3:0] draw, input logic [3:0] p3, input logic [3:0] p2,
                         input logic [3:0] p1, input logic [3:0] p0, input logic br);
        spr_draw = draw;
        spr_pix  = {p3, p2, p1, p0};
        bright   = br;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t m;
                m = q.pop_front();
                if (m.c_pix) begin
                    chk("pix_idx", m.tag, 32'(pix_idx), 32'(m.idx));
                    chk("pix_valid", m.tag, 32'(pix_valid), 32'(m.vld));
                    chk("bright_d", m.tag, 32'(bright_d), 32'(m.bd));
                end
                if (m.c_cm)
                    chk("commit", m.tag, 32'(commit), 32'(m.cm));
                if (m.c_col) begin
                    chk("collision", m.tag, 32'(collision), 32'(m.col));
                    chk("coll_any", m.tag, 32'(coll_any), 32'(|m.col));
                end
                if (m.c_pos) begin
                    chk("sprx_out", m.tag, 32'(sprx_out[m.spr*16 +: 16]), 32'(m.x));
                    chk("spry_out", m.tag, 32'(spry_out[m.spr*16 +: 16]), 32'(m.y));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; frame = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        drive(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        clr_exp();

        // Reset state
        expix(4'h0, 1'b0, 1'b0); excm(1'b0); excol(4'h0); expos(0, 16'd0, 16'd0);
        tick();
        rst = 1'b0;

        // Two frames with nothing written
        tick();
        frame = 1'b1; excm(1'b0); excol(4'h0); expos(0, 16'd0, 16'd0); tick();
        frame = 1'b0; excm(1'b0); tick();
        frame = 1'b1; excm(1'b0); expos(3, 16'd0, 16'd0); tick();
        frame = 1'b0; excm(1'b0); tick();

        // Shadow writes stay invisible until the frame commit
        wr(4'd0, 16'd100);
        wr(4'd1, 16'd50);
        wr(4'd8, 16'h0001);
        expos(0, 16'd0, 16'd0); excm(1'b0); tick();
        frame = 1'b1; excm(1'b1); expos(0, 16'd100, 16'd50); tick();
        frame = 1'b0; excm(1'b0); expos(0, 16'd100, 16'd50); tick();

        // Enable all sprites, then priority selection
        wr(4'd8, 16'h000F);
        frame = 1'b1; excm(1'b1); tick();
        frame = 1'b0;
        drive(4'b0110, 4'h0, 4'h7, 4'h3, 4'h0, 1'b1); expix(4'h3, 1'b1, 1'b1); excm(1'b0); tick();
        drive(4'b0110, 4'h0, 4'h7, 4'hF, 4'h0, 1'b1); expix(4'h7, 1'b1, 1'b1); tick();
        drive(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0); expix(4'h0, 1'b0, 1'b0); tick();

        // Frame publishes the 1/2 overlap; overlap in the frame cycle itself is dropped
        frame = 1'b1;
        drive(4'b1001, 4'h9, 4'h0, 4'h0, 4'h5, 1'b1); expix(4'h5, 1'b1, 1'b1); excol(4'b0110); excm(1'b0); tick();
        frame = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expix(4'h5, 1'b1, 1'b1); excol(4'b0110); tick();
        end
        // Overlap during blanking must not accumulate
        drive(4'b0110, 4'h0, 4'h7, 4'h3, 4'h0, 1'b0); expix(4'h3, 1'b1, 1'b0); tick();
        drive(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        frame = 1'b1; excol(4'b1001); tick();
        frame = 1'b0;
        excol(4'b1001); tick();
        // All drawing but transparent: nothing selected, nothing collides
        drive(4'b1111, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1); expix(4'h0, 1'b0, 1'b1); excol(4'b1001); tick();
        drive(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        frame = 1'b1; excol(4'h0); tick();
        frame = 1'b0; excol(4'h0); tick();

        // Write coinciding with a clean frame commits on the next frame
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'd200; frame = 1'b1;
        excm(1'b0); expos(1, 16'd0, 16'd0); tick();
        wr_en = 1'b0; frame = 1'b0;
        excm(1'b0); expos(1, 16'd0, 16'd0); tick();
        frame = 1'b1; excm(1'b1); expos(1, 16'd200, 16'd0); tick();
        frame = 1'b0; excm(1'b0); tick();

        // Out-of-range address is ignored and leaves dirty clear
        wr(4'd12, 16'h1234);
        frame = 1'b1; excm(1'b0); expos(0, 16'd100, 16'd50); tick();
        frame = 1'b0; expos(2, 16'd0, 16'd0); tick();

        // Reset with a pending write clears everything and cancels the commit
        wr(4'd0, 16'd7);
        drive(4'b0001, 4'h0, 4'h0, 4'h0, 4'h5, 1'b1);
        rst = 1'b1;
        expix(4'h0, 1'b0, 1'b0); excm(1'b0); excol(4'h0); expos(0, 16'd0, 16'd0); tick();
        rst = 1'b0;
        frame = 1'b1; expix(4'h0, 1'b0, 1'b1); excm(1'b0); expos(0, 16'd0, 16'd0); tick();
        frame = 1'b0; excm(1'b0); expos(1, 16'd0, 16'd0); tick();

        drive(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        repeat (2) @(negedge clk);
        chk("queue_drain", 0, 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised N-sprite compositor between the sprite engines and the colour lookup/VGA output stage.
- Holds double-buffered per-sprite positions and enables, loaded over a small write port from the memory/VGA fetch path. Positions commit only at frame start, so no tearing.
- Each pixel clock, picks the highest-priority opaque sprite pixel and registers it. Also accumulates per-sprite collision flags over each frame.

Parameters:
- NSPR, 4, number of sprite channels (2..8).
- CORDW, 16, signed coordinate width.
- CIDXW, 4, colour index width.
- TRANS_INDX, 4'hF, transparent colour index.
- ADDRW, 4, write address width; must satisfy 2^ADDRW > 2*NSPR.

Ports:
- clk  in  1  pixel clock (25 MHz domain).
- rst  in  1  synchronous reset, active-high.
- frame  in  1  one-cycle start-of-frame pulse (occurs in blanking).
- bright  in  1  active-video flag for the current pixel.
- wr_en  in  1  shadow register write strobe.
- wr_addr  in  ADDRW  register address: 2i = x of sprite i, 2i+1 = y of sprite i, 2*NSPR = enable mask.
- wr_data  in  CORDW  write data.
- spr_draw  in  NSPR  per-sprite drawing flag from the sprite engines.
- spr_pix  in  NSPR*CIDXW  per-sprite pixel index; sprite i at [i*CIDXW +: CIDXW].
- sprx_out  out  NSPR*CORDW  committed x positions, same packing.
- spry_out  out  NSPR*CORDW  committed y positions.
- pix_idx  out  CIDXW  winning colour index (registered).
- pix_valid  out  1  an opaque sprite pixel was selected (registered).
- bright_d  out  1  bright delayed to align with pix_idx.
- collision  out  NSPR  per-sprite collision flags for the previous frame.
- coll_any  out  1  OR of collision.
- commit  out  1  one-cycle pulse, the cycle after a shadow-to-active commit.

Behaviour:
- Reset: all shadow/active x, y = 0; enable shadow/active = 0; dirty = 0. pix_idx = 0, pix_valid = 0, bright_d = 0, collision = 0, coll_acc = 0, commit = 0. Reset overrides every other event in the same cycle.
- Write:
  - wr_en with a valid address updates the shadow register and sets dirty.
  - The enable mask takes wr_data[NSPR-1:0].
  - Addresses above 2*NSPR are ignored; dirty is unchanged.
- Commit:
  - On frame with dirty = 1: all active <= shadow, dirty cleared, commit = 1 next cycle.
  - On frame with dirty = 0: no change, commit stays 0.
- Simultaneous wr_en and frame:
  - The commit uses the pre-write shadow values.
  - The new write lands in shadow and dirty ends up 1, so it commits at the next frame.
- Opaque term: opq[i] = en_active[i] & spr_draw[i] & (spr_pix_i != TRANS_INDX).
- Priority: lowest index wins.
  - pix_idx <= winner's index, pix_valid <= |opq.
  - If nothing is opaque: pix_idx <= 0, pix_valid <= 0.
  - bright_d <= bright.
  - Latency is exactly 1 clock for all three outputs.
- Collision accumulation:
  - When bright = 1 and at least two opq bits are set, coll_acc[i] |= opq[i].
  - When bright = 0, no accumulation.
- Collision frame boundary:
  - On frame: collision <= coll_acc and coll_acc <= 0; contributions in the frame cycle itself are discarded.
  - collision is held constant for the whole following frame.
- coll_any is combinational from the collision register.
- Active position/enable registers drive sprx_out/spry_out directly (registered, no combinational path from wr_*).

Test Plan:
- Reset, then 2 frames with no writes -> all outputs 0, commit never pulses.
- Write x0 = 100, y0 = 50, enable = 4'b0001, then frame -> sprx_out[15:0] changes from 0 to 100 only after frame, spry_out[15:0] = 50, commit high exactly 1 cycle after frame.
- enable = 4'b1111; spr_draw = 4'b0110, pix1 = 3, pix2 = 7, bright = 1 -> next cycle pix_idx = 3, pix_valid = 1. Then pix1 = 4'hF -> pix_idx = 7.
- During frame N, overlap sprites 0 and 3 (both opaque, bright = 1) for 5 cycles; frame -> collision = 4'b1001, coll_any = 1. Frame N+1 with no overlap, then frame -> collision = 0.
- wr_en to x1 = 200 in the same cycle as frame with dirty = 0 -> no commit. Next frame -> x1 active = 200, commit pulses.
- wr_addr = 4'd12 (NSPR = 4) then frame -> no register change, commit stays 0. Assert rst mid-frame with dirty = 1 -> everything 0 the next cycle, no commit at the following frame.
